// File: rtl/syncfifo_lvl_if.sv
// ---------------------------------------------------------------------------
// syncfifo_lvl_if
//   Bundles the data, handshake and status signals of syncfifo_lvl so that
//   producer, consumer and FIFO share one connection point.
//
// Parameters
//   WIDTH : data word width in bits
//   DEPTH : number of storage words (sets the width of level/peak_level)
//
// Signals
//   din, wr_en, rd_en, wm_clear         : driven by the user (master)
//   dout, empty, full, almost_empty,
//   almost_full, level, overflow,
//   underflow, peak_level               : driven by the FIFO (slave)
// ---------------------------------------------------------------------------
interface syncfifo_lvl_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 12
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic             wm_clear;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;
  logic [LW-1:0]    peak_level;

  modport master (
    output din, wr_en, rd_en, wm_clear,
    input  dout, empty, full, almost_empty, almost_full,
           level, overflow, underflow, peak_level
  );

  modport slave (
    input  din, wr_en, rd_en, wm_clear,
    output dout, empty, full, almost_empty, almost_full,
           level, overflow, underflow, peak_level
  );
endinterface

// File: rtl/syncfifo_lvl.sv
// ---------------------------------------------------------------------------
// syncfifo_lvl
//   Single-clock FIFO of arbitrary depth with fill level, programmable
//   almost-full / almost-empty flags and overflow / underflow pulses.
//   Read mode is either standard (dout registered on an accepted read) or
//   first-word-fall-through (head word always presented on dout).
//
// Parameters
//   WIDTH : data word width
//   DEPTH : storage words, any integer >= 2
//   FWFT  : 0 = standard read, 1 = first-word-fall-through
//   AF_TH : almost_full  when level >= AF_TH
//   AE_TH : almost_empty when level <= AE_TH
//
// Ports
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : syncfifo_lvl_if.slave (data, handshake, flags, level)
//
// Optional feature
//   `define SYNCFIFO_LVL_WATERMARK_EN to build the peak_level high-water
//   mark (cleared by wm_clear). Without it peak_level is tied to 0.
// ---------------------------------------------------------------------------
module syncfifo_lvl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 12,
  parameter int FWFT  = 0,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2
) (
  input logic           clk,
  input logic           reset_n,
  syncfifo_lvl_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // Elaboration-time parameter sanity checks
  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("syncfifo_lvl: DEPTH must be >= 2");
    end
    if (AF_TH > DEPTH) begin : g_bad_af
      $error("syncfifo_lvl: AF_TH must be <= DEPTH");
    end
    if (AE_TH >= DEPTH) begin : g_bad_ae
      $error("syncfifo_lvl: AE_TH must be < DEPTH");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
      $error("syncfifo_lvl: FWFT must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_next, rd_ptr_next;
  logic [LW-1:0]    level_reg, level_next;
  logic [WIDTH-1:0] dout_reg;
  logic             empty_reg, full_reg;
  logic             almost_empty_reg, almost_full_reg;
  logic             overflow_reg, underflow_reg;
  logic             rd_acc, wr_acc;

  // Explicit wrap so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // A write into a full FIFO is allowed only when a read frees a slot in
  // the same cycle; a read of an empty FIFO is never allowed (no bypass).
  assign rd_acc = bus.rd_en && !empty_reg;
  assign wr_acc = bus.wr_en && (!full_reg || rd_acc);

  assign wr_ptr_next = wr_acc ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
  assign rd_ptr_next = rd_acc ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

  always_comb begin
    level_next = level_reg;
    if (wr_acc && !rd_acc) begin
      level_next = level_reg + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_next = level_reg - LW'(1);
    end
  end

  // Storage: not reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= bus.din;
    end
  end

  // Pointers, level and flags; flags come from the next level so they are
  // registered yet consistent with level in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      level_reg        <= level_next;
      empty_reg        <= (level_next == '0);
      full_reg         <= (level_next == LW'(DEPTH));
      almost_empty_reg <= (level_next <= LW'(AE_TH));
      almost_full_reg  <= (level_next >= LW'(AF_TH));
      overflow_reg     <= bus.wr_en && !wr_acc;
      underflow_reg    <= bus.rd_en && !rd_acc;
    end
  end

  // Read data path
  generate
    if (FWFT == 1) begin : g_fwft
      // Keep dout loaded with the word that will be at the head after this
      // edge. When that head is the word being written right now (write
      // into empty, or read+write at level 1) it is not yet in the array,
      // so take it from din instead.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          dout_reg <= '0;
        end else if (level_next != '0) begin
          if (wr_acc && (wr_ptr_reg == rd_ptr_next)) begin
            dout_reg <= bus.din;
          end else begin
            dout_reg <= mem[rd_ptr_next];
          end
        end
      end
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          dout_reg <= '0;
        end else if (rd_acc) begin
          dout_reg <= mem[rd_ptr_reg];
        end
      end
    end
  endgenerate

  // High-water mark
`ifdef SYNCFIFO_LVL_WATERMARK_EN
  logic [LW-1:0] peak_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      peak_reg <= '0;
    end else if (bus.wm_clear) begin
      peak_reg <= level_next;
    end else if (level_next > peak_reg) begin
      peak_reg <= level_next;
    end
  end

  assign bus.peak_level = peak_reg;
`else
  logic unused_wm_clear;
  assign unused_wm_clear = bus.wm_clear;
  assign bus.peak_level  = '0;
`endif

  assign bus.dout         = dout_reg;
  assign bus.empty        = empty_reg;
  assign bus.full         = full_reg;
  assign bus.almost_empty = almost_empty_reg;
  assign bus.almost_full  = almost_full_reg;
  assign bus.level        = level_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_syncfifo_lvl.sv
// ---------------------------------------------------------------------------
// tb_syncfifo_lvl
//   Directed bench for syncfifo_lvl (WIDTH=8, DEPTH=5, AF_TH=4, AE_TH=1).
//   A standard-mode and an FWFT-mode instance receive identical stimulus;
//   expected values are written out by hand for each step.
// ---------------------------------------------------------------------------
module tb_syncfifo_lvl;
  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
`ifdef SYNCFIFO_LVL_WATERMARK_EN
  localparam int WM = 1;
`else
  localparam int WM = 0;
`endif

  logic         clk      = 1'b0;
  logic         reset_n  = 1'b0;
  logic [W-1:0] din      = '0;
  logic         wr_en    = 1'b0;
  logic         rd_en    = 1'b0;
  logic         wm_clear = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0] drain_exp [5] = '{8'h52, 8'h53, 8'h54, 8'h55, 8'h77};

  always #5 clk = ~clk;

  syncfifo_lvl_if #(.WIDTH(W), .DEPTH(D)) bus_std ();
  syncfifo_lvl_if #(.WIDTH(W), .DEPTH(D)) bus_fw ();

  assign bus_std.din      = din;
  assign bus_std.wr_en    = wr_en;
  assign bus_std.rd_en    = rd_en;
  assign bus_std.wm_clear = wm_clear;
  assign bus_fw.din       = din;
  assign bus_fw.wr_en     = wr_en;
  assign bus_fw.rd_en     = rd_en;
  assign bus_fw.wm_clear  = wm_clear;

  syncfifo_lvl #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_TH(AF), .AE_TH(AE)) u_std (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_std)
  );

  syncfifo_lvl #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_TH(AF), .AE_TH(AE)) u_fw (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_fw)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge
  task automatic op(input logic w, input logic r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    $display("t=%0t wr=%0b rd=%0b din=%02h rst_n=%0b -> level=%0d dout_std=%02h dout_fw=%02h ovf=%0b udf=%0b",
             $time, w, r, d, reset_n, bus_std.level, bus_std.dout, bus_fw.dout,
             bus_std.overflow, bus_std.underflow);
  endtask

  // Push n consecutive words into an empty FIFO
  task automatic push_run(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      op(1'b1, 1'b0, 8'(base + i));
      check("push level", 32'(bus_std.level), i + 1);
    end
    check("push fwft head", 32'(bus_fw.dout), base);
  endtask

  // Pop exactly n consecutive words, draining the FIFO
  task automatic pop_run(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      op(1'b0, 1'b1, 8'h00);
      check("pop std dout", 32'(bus_std.dout), base + i);
      check("pop fwft dout", 32'(bus_fw.dout), (i < n - 1) ? base + i + 1 : base + n - 1);
      check("pop level", 32'(bus_std.level), n - 1 - i);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    check("rst level", 32'(bus_std.level), 0);
    check("rst empty", 32'(bus_std.empty), 1);
    check("rst almost_empty", 32'(bus_std.almost_empty), 1);
    check("rst full", 32'(bus_std.full), 0);
    check("rst almost_full", 32'(bus_std.almost_full), 0);
    check("rst overflow", 32'(bus_std.overflow), 0);
    check("rst underflow", 32'(bus_std.underflow), 0);
    check("rst dout std", 32'(bus_std.dout), 0);
    check("rst dout fwft", 32'(bus_fw.dout), 0);
    check("rst peak", 32'(bus_std.peak_level), 0);

    // Fill 0x11..0x15 with flag thresholds
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, 8'(8'h11 + i));
      check("fill level", 32'(bus_std.level), i + 1);
      check("fill almost_empty", 32'(bus_std.almost_empty), (i + 1 <= AE) ? 1 : 0);
      check("fill almost_full", 32'(bus_std.almost_full), (i + 1 >= AF) ? 1 : 0);
      check("fill full", 32'(bus_std.full), (i == 4) ? 1 : 0);
      check("fill empty", 32'(bus_std.empty), 0);
    end
    check("fill fwft head", 32'(bus_fw.dout), 8'h11);
    check("fill peak", 32'(bus_std.peak_level), (WM != 0) ? 5 : 0);

    // Overflow
    op(1'b1, 1'b0, 8'h16);
    check("ovf pulse", 32'(bus_std.overflow), 1);
    check("ovf level", 32'(bus_std.level), 5);
    op(1'b0, 1'b0, 8'h00);
    check("ovf clear", 32'(bus_std.overflow), 0);
    check("ovf full", 32'(bus_std.full), 1);

    // Drain and underflow
    pop_run(8'h11, 5);
    op(1'b0, 1'b1, 8'h00);
    check("udf pulse", 32'(bus_std.underflow), 1);
    check("udf empty", 32'(bus_std.empty), 1);
    check("udf dout hold", 32'(bus_std.dout), 8'h15);
    op(1'b0, 1'b0, 8'h00);
    check("udf clear", 32'(bus_std.underflow), 0);

    // Pointer wrap 4 -> 0
    push_run(8'h31, 3);
    pop_run(8'h31, 3);
    push_run(8'hA0, 4);
    pop_run(8'hA0, 4);
    check("wrap empty", 32'(bus_std.empty), 1);

    // Full with simultaneous read and write
    push_run(8'h51, 5);
    op(1'b1, 1'b1, 8'h77);
    check("fullrw overflow", 32'(bus_std.overflow), 0);
    check("fullrw level", 32'(bus_std.level), 5);
    check("fullrw full", 32'(bus_std.full), 1);
    check("fullrw std dout", 32'(bus_std.dout), 8'h51);
    check("fullrw fwft dout", 32'(bus_fw.dout), 8'h52);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 1'b1, 8'h00);
      check("fullrw drain std", 32'(bus_std.dout), 32'(drain_exp[i]));
      check("fullrw drain fwft", 32'(bus_fw.dout), (i < 4) ? 32'(drain_exp[i + 1]) : 32'h77);
      check("fullrw drain level", 32'(bus_std.level), 4 - i);
    end

    // Empty with simultaneous read and write
    op(1'b1, 1'b1, 8'h42);
    check("emptyrw underflow", 32'(bus_std.underflow), 1);
    check("emptyrw level", 32'(bus_std.level), 1);
    check("emptyrw fwft dout", 32'(bus_fw.dout), 8'h42);
    check("emptyrw std dout", 32'(bus_std.dout), 8'h77);
    op(1'b0, 1'b0, 8'h00);
    check("emptyrw udf clear", 32'(bus_std.underflow), 0);
    check("emptyrw std hold", 32'(bus_std.dout), 8'h77);
    op(1'b0, 1'b1, 8'h00);
    check("emptyrw std pop", 32'(bus_std.dout), 8'h42);
    check("emptyrw level0", 32'(bus_std.level), 0);

    // Read and write together at level 1
    op(1'b1, 1'b0, 8'h61);
    check("lvl1 fwft head", 32'(bus_fw.dout), 8'h61);
    op(1'b1, 1'b1, 8'h62);
    check("lvl1rw level", 32'(bus_std.level), 1);
    check("lvl1rw std dout", 32'(bus_std.dout), 8'h61);
    check("lvl1rw fwft dout", 32'(bus_fw.dout), 8'h62);
    check("lvl1rw underflow", 32'(bus_std.underflow), 0);
    op(1'b0, 1'b1, 8'h00);
    check("lvl1rw std pop", 32'(bus_std.dout), 8'h62);
    check("lvl1rw empty", 32'(bus_std.empty), 1);

    // FWFT back-to-back writes, then held read
    op(1'b1, 1'b0, 8'h01);
    check("fwft first", 32'(bus_fw.dout), 8'h01);
    op(1'b1, 1'b0, 8'h02);
    check("fwft still head", 32'(bus_fw.dout), 8'h01);
    op(1'b0, 1'b1, 8'h00);
    check("fwft second", 32'(bus_fw.dout), 8'h02);
    check("fwft level1", 32'(bus_fw.level), 1);
    op(1'b0, 1'b1, 8'h00);
    check("fwft empty", 32'(bus_fw.empty), 1);
    check("fwft no underflow", 32'(bus_fw.underflow), 0);
    check("fwft hold", 32'(bus_fw.dout), 8'h02);
    check("std after two pops", 32'(bus_std.dout), 8'h02);
    op(1'b0, 1'b0, 8'h00);

    // Reset mid-operation at level 3
    push_run(8'h91, 3);
    reset_n = 1'b0;
    op(1'b1, 1'b1, 8'h99);
    reset_n = 1'b1;
    check("mrst level", 32'(bus_std.level), 0);
    check("mrst empty", 32'(bus_std.empty), 1);
    check("mrst std dout", 32'(bus_std.dout), 0);
    check("mrst fwft dout", 32'(bus_fw.dout), 0);
    check("mrst underflow", 32'(bus_std.underflow), 0);
    check("mrst peak", 32'(bus_std.peak_level), 0);
    op(1'b0, 1'b0, 8'h00);
    check("mrst write ignored", 32'(bus_std.level), 0);

    // High-water mark
    push_run(8'hC1, 4);
    pop_run(8'hC1, 4);
    check("peak after fill4", 32'(bus_std.peak_level), (WM != 0) ? 4 : 0);
    op(1'b1, 1'b0, 8'hD1);
    check("peak kept", 32'(bus_std.peak_level), (WM != 0) ? 4 : 0);
    wm_clear = 1'b1;
    op(1'b0, 1'b0, 8'h00);
    wm_clear = 1'b0;
    check("peak cleared", 32'(bus_std.peak_level), (WM != 0) ? 1 : 0);
    op(1'b0, 1'b1, 8'h00);
    check("final std dout", 32'(bus_std.dout), 8'hD1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
